sprite_dma_engine: RTL and testbench

- Parametrised OAM DMA engine.
- A CPU write to a trigger address latches a source page, halts the CPU, and copies LEN bytes from CPU-side memory to a destination RAM.
- Adds to the fixed 256-byte copy: a cycle-enable strobe, configurable read latency, an odd-cycle alignment stall, a destination start offset with wrap, and a done pulse.
- Sits between the CPU bus, the work-RAM read port and the OAM write port; `halt` drives CPU enable low.

---
 rtl/sprite_dma_engine.sv | 147 ++++++++++++++
 tb/tb_sprite_dma_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_dma_engine.sv
// OAM-style sprite DMA: a CPU write to TRIG_ADDR halts the CPU and copies LEN
// bytes from page<<8 of the source memory into the destination RAM.
module sprite_dma_engine #(
  parameter logic [15:0] TRIG_ADDR    = 16'h4014,
  parameter int          LEN          = 256,
  parameter int          DST_W        = 8,
  parameter int          READ_LATENCY = 1,
  parameter bit          ALIGN_EN     = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ce,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_wr,
  input  logic [7:0]       cpu_dout,
  input  logic [DST_W-1:0] oam_start,
  output logic             halt,
  output logic             busy,
  output logic             done,
  output logic [15:0]      mem_addr,
  output logic             mem_rd,
  input  logic [7:0]       mem_rdata,
  output logic [DST_W-1:0] dst_addr,
  output logic [7:0]       dst_data,
  output logic             dst_wren
);

  localparam int                CNT_W     = DST_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LEN - 1);
  localparam logic [2:0]        WAIT_LAST = 3'(READ_LATENCY - 2);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic             parity_reg;
  logic [15:0]      src_reg, src_next;
  logic [DST_W-1:0] dst_reg, dst_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       wait_reg, wait_next;
  logic [7:0]       data_reg, data_next;
  logic             trigger;

  assign trigger = ce && cpu_wr && (cpu_addr == TRIG_ADDR);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      parity_reg <= 1'b0;
      src_reg    <= '0;
      dst_reg    <= '0;
      cnt_reg    <= '0;
      wait_reg   <= '0;
      data_reg   <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      cnt_reg   <= cnt_next;
      wait_reg  <= wait_next;
      data_reg  <= data_next;
      if (ce) begin
        parity_reg <= ~parity_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    cnt_next   = cnt_reg;
    wait_next  = wait_reg;
    data_next  = data_reg;
    mem_rd     = 1'b0;
    dst_wren   = 1'b0;
    dst_data   = data_reg;
    busy       = (state_reg != IDLE) && (state_reg != DONE);
    halt       = busy;
    done       = (state_reg == DONE);
    mem_addr   = src_reg;
    dst_addr   = dst_reg;

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          src_next   = {cpu_dout, 8'h00};
          dst_next   = oam_start;
          cnt_next   = '0;
          state_next = HALT;
        end
      end
      HALT: begin
        if (ce) begin
          state_next = (ALIGN_EN && parity_reg) ? ALIGN : READ;
        end
      end
      ALIGN: begin
        if (ce) begin
          state_next = READ;
        end
      end
      READ: begin
        mem_rd = ce;
        if (ce) begin
          wait_next  = '0;
          state_next = (READ_LATENCY == 1) ? WRITE : WAIT;
        end
      end
      WAIT: begin
        if (ce) begin
          if (wait_reg == WAIT_LAST) begin
            state_next = WRITE;
          end else begin
            wait_next = wait_reg + 3'd1;
          end
        end
      end
      WRITE: begin
        // Data is passed straight through in the write cycle, then held.
        dst_data = mem_rdata;
        dst_wren = ce;
        if (ce) begin
          data_next  = mem_rdata;
          src_next   = src_reg + 16'd1;
          dst_next   = dst_reg + DST_W'(1);
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = (cnt_reg == LAST_CNT) ? DONE : READ;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sprite_dma_engine.sv
// Randomised bench for sprite_dma_engine: a default instance and a
// LEN=4 / READ_LATENCY=3 instance, checked against a transfer-level model.
module tb_sprite_dma_engine;

  localparam logic [15:0] TRIG = 16'h4014;

  logic Clk = 1'b0;
  logic Reset;

  logic [1:0]       ce_v;
  logic [1:0][15:0] cpu_addr_v;
  logic [1:0]       cpu_wr_v;
  logic [1:0][7:0]  cpu_dout_v;
  logic [1:0][7:0]  oam_start_v;

  logic        halt0, busy0, done0, mem_rd0, dst_wren0;
  logic        halt1, busy1, done1, mem_rd1, dst_wren1;
  logic [15:0] mem_addr0, mem_addr1;
  logic [7:0]  dst_addr0, dst_addr1, dst_data0, dst_data1;

  logic [1:0]       halt_v, busy_v, done_v, mem_rd_v, dst_wren_v;
  logic [1:0][15:0] mem_addr_v;
  logic [1:0][7:0]  dst_addr_v, dst_data_v;

  assign halt_v     = {halt1, halt0};
  assign busy_v     = {busy1, busy0};
  assign done_v     = {done1, done0};
  assign mem_rd_v   = {mem_rd1, mem_rd0};
  assign dst_wren_v = {dst_wren1, dst_wren0};
  assign mem_addr_v = {mem_addr1, mem_addr0};
  assign dst_addr_v = {dst_addr1, dst_addr0};
  assign dst_data_v = {dst_data1, dst_data0};

  int n_cmp = 0;
  int n_bad = 0;
  int ce_cnt [2];

  logic [7:0] pipe0;
  logic [7:0] pipe1 [3];

  always #5 Clk = ~Clk;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return 8'(a[7:0] * 8'd7 + a[15:8] * 8'd13 + 8'h5A);
  endfunction

  // Source memories: data appears READ_LATENCY ce cycles after the request.
  always @(posedge Clk) begin
    if (ce_v[0]) pipe0 <= mem_rd_v[0] ? src_byte(mem_addr_v[0]) : 8'h00;
    if (ce_v[1]) begin
      pipe1[0] <= mem_rd_v[1] ? src_byte(mem_addr_v[1]) : 8'h00;
      pipe1[1] <= pipe1[0];
      pipe1[2] <= pipe1[1];
    end
  end

  // Number of ce edges since reset; its low bit is the cycle parity.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ce_cnt[0] <= 0;
      ce_cnt[1] <= 0;
    end else begin
      if (ce_v[0]) ce_cnt[0] <= ce_cnt[0] + 1;
      if (ce_v[1]) ce_cnt[1] <= ce_cnt[1] + 1;
    end
  end

  sprite_dma_engine u_dut0 (
    .Clk(Clk), .Reset(Reset), .ce(ce_v[0]), .cpu_addr(cpu_addr_v[0]),
    .cpu_wr(cpu_wr_v[0]), .cpu_dout(cpu_dout_v[0]), .oam_start(oam_start_v[0]),
    .halt(halt0), .busy(busy0), .done(done0), .mem_addr(mem_addr0),
    .mem_rd(mem_rd0), .mem_rdata(pipe0), .dst_addr(dst_addr0),
    .dst_data(dst_data0), .dst_wren(dst_wren0)
  );

  sprite_dma_engine #(.LEN(4), .READ_LATENCY(3)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .ce(ce_v[1]), .cpu_addr(cpu_addr_v[1]),
    .cpu_wr(cpu_wr_v[1]), .cpu_dout(cpu_dout_v[1]), .oam_start(oam_start_v[1]),
    .halt(halt1), .busy(busy1), .done(done1), .mem_addr(mem_addr1),
    .mem_rd(mem_rd1), .mem_rdata(pipe1[2]), .dst_addr(dst_addr1),
    .dst_data(dst_data1), .dst_wren(dst_wren1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int i);
    return 64'({halt_v[i], busy_v[i], done_v[i], mem_rd_v[i], dst_wren_v[i],
                mem_addr_v[i], dst_addr_v[i], dst_data_v[i]});
  endfunction

  task automatic non_trigger(input int inst);
    @(posedge Clk); #1;
    ce_v[inst] = 1'b1; cpu_addr_v[inst] = 16'h4015; cpu_wr_v[inst] = 1'b1;
    cpu_dout_v[inst] = 8'($urandom);
    @(posedge Clk); #1;
    cpu_addr_v[inst] = TRIG; cpu_wr_v[inst] = 1'b0;
    @(negedge Clk);
    check_eq("busy_after_4015_write", busy_v[inst], 0);
    @(posedge Clk); #1;
    cpu_wr_v[inst] = 1'b1; ce_v[inst] = 1'b0;
    @(negedge Clk);
    check_eq("busy_after_trig_read", busy_v[inst], 0);
    @(posedge Clk); #1;
    cpu_wr_v[inst] = 1'b0; ce_v[inst] = 1'b1;
    @(negedge Clk);
    check_eq("busy_after_ce0_write", busy_v[inst], 0);
    $display("non-trigger accesses inst%0d", inst);
  endtask

  task automatic run_xfer(input int inst, input logic [7:0] page, input logic [7:0] start,
                          input int ce_period, input int want_par, input int retrig_byte,
                          input int rst_byte, input bit trig_on_done);
    int len, rl, align, exp_halt, halt_ce, done_clks, wr_n, rd_n, ce_k, k, last_wr_k, stray;
    bit ce_now, done_trig, retrig_sent, finished, aborted;
    logic [15:0] base;
    len = (inst == 0) ? 256 : 4;
    rl  = (inst == 0) ? 1 : 3;
    base = {page, 8'h00};
    halt_ce = 0; done_clks = 0; wr_n = 0; rd_n = 0; ce_k = 0; k = 0;
    last_wr_k = -10; stray = 0;
    done_trig = 0; retrig_sent = 0; finished = 0; aborted = 0;

    @(posedge Clk); #1;
    ce_v[inst] = 1'b1; cpu_wr_v[inst] = 1'b0;
    if (ce_cnt[inst] % 2 != want_par) begin
      @(posedge Clk); #1;
    end
    // The halt cycle is the next ce cycle; it stalls when its parity is odd.
    align = (ce_cnt[inst] % 2 == 0) ? 1 : 0;
    exp_halt = 1 + align + len * (rl + 1);
    cpu_addr_v[inst] = TRIG; cpu_wr_v[inst] = 1'b1;
    cpu_dout_v[inst] = page; oam_start_v[inst] = start;
    @(negedge Clk);
    check_eq("idle_before_trig", busy_v[inst], 0);

    while (!finished && k < 4000) begin
      @(posedge Clk); #1;
      k++;
      ce_now = (k % ce_period == 0) || done_trig;
      ce_v[inst] = ce_now;
      cpu_wr_v[inst] = 1'b0;
      cpu_addr_v[inst] = 16'($urandom);
      cpu_dout_v[inst] = 8'($urandom);
      oam_start_v[inst] = 8'($urandom);
      if (done_trig) begin
        cpu_addr_v[inst] = TRIG; cpu_wr_v[inst] = 1'b1; cpu_dout_v[inst] = ~page;
        done_trig = 0;
      end else if (!retrig_sent && retrig_byte >= 0 && wr_n == retrig_byte && ce_now) begin
        cpu_addr_v[inst] = TRIG; cpu_wr_v[inst] = 1'b1; cpu_dout_v[inst] = 8'h05;
        retrig_sent = 1;
      end
      if (rst_byte >= 0 && wr_n == rst_byte) begin
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("outs_in_reset", outs(inst), 64'd0);
        @(posedge Clk); #1;
        Reset = 1'b0; cpu_wr_v[inst] = 1'b0; ce_v[inst] = 1'b1;
        repeat (8) begin
          @(negedge Clk);
          stray += int'(busy_v[inst]) + int'(done_v[inst]) + int'(dst_wren_v[inst]);
          @(posedge Clk); #1;
        end
        check_eq("quiet_after_reset", stray, 0);
        aborted = 1; finished = 1;
      end else begin
        if (ce_now) ce_k++;
        @(negedge Clk);
        if (k == 1) check_eq("busy_halt_rise", {busy_v[inst], halt_v[inst]}, 2'b11);
        if (ce_now && halt_v[inst]) halt_ce++;
        if (!ce_now) check_eq("strobe_on_ce0", {mem_rd_v[inst], dst_wren_v[inst]}, 2'b00);
        if (mem_rd_v[inst]) begin
          if (rd_n == 0) check_eq("first_rd_ce", ce_k, 2 + align);
          check_eq("rd_addr", mem_addr_v[inst], base + 16'(rd_n));
          rd_n++;
        end
        if (dst_wren_v[inst]) begin
          check_eq("wr_addr", dst_addr_v[inst], 8'(start + 8'(wr_n)));
          check_eq("wr_data", dst_data_v[inst], src_byte(base + 16'(wr_n)));
          wr_n++;
          last_wr_k = k;
          if (trig_on_done && wr_n == len) done_trig = 1;
        end
        if (done_v[inst]) begin
          done_clks++;
          check_eq("done_after_last_wr", k - last_wr_k, 1);
          check_eq("drop_at_done", {busy_v[inst], halt_v[inst]}, 2'b00);
        end else if (done_clks > 0) begin
          check_eq("idle_after_done", {busy_v[inst], halt_v[inst]}, 2'b00);
          finished = 1;
        end
      end
    end

    check_eq("xfer_ended", finished, 1);
    if (!aborted) begin
      check_eq("wr_count", wr_n, len);
      check_eq("rd_count", rd_n, len);
      check_eq("halt_ce_cycles", halt_ce, exp_halt);
      check_eq("done_pulses", done_clks, 1);
    end
    cpu_wr_v[inst] = 1'b0;
    $display("xfer inst%0d page=%02h start=%02h ce_per=%0d align=%0d writes=%0d halt_ce=%0d/%0d %s",
             inst, page, start, ce_period, align, wr_n, halt_ce, exp_halt,
             aborted ? "reset-aborted" : "complete");
  endtask

  initial begin
    Reset = 1'b0;
    ce_v = '0; cpu_addr_v = '0; cpu_wr_v = '0; cpu_dout_v = '0; oam_start_v = '0;
    #2 Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check_eq("reset_outs_inst0", outs(0), 64'd0);
    check_eq("reset_outs_inst1", outs(1), 64'd0);

    non_trigger(0);
    non_trigger(1);

    run_xfer(0, 8'h02, 8'h00, 1, 1, -1, -1, 1'b0);
    run_xfer(0, 8'h02, 8'h00, 1, 0, -1, -1, 1'b0);
    run_xfer(0, 8'($urandom), 8'hF0, 1, int'($urandom_range(0, 1)), -1, -1, 1'b1);
    run_xfer(0, 8'h02, 8'h00, 1, 1, 10, 100, 1'b0);
    run_xfer(0, 8'($urandom), 8'($urandom), 1, int'($urandom_range(0, 1)), -1, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_xfer(1, 8'($urandom), 8'($urandom),
               (i < 2) ? 3 : int'($urandom_range(1, 4)), i % 2, -1, -1, i == 3);
    end
    run_xfer(1, 8'h02, 8'hFE, 3, 1, 1, -1, 1'b0);
    run_xfer(1, 8'($urandom), 8'($urandom), 2, 0, -1, 2, 1'b0);
    run_xfer(1, 8'($urandom), 8'($urandom), 1, 1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
